trojan_trigger_param: RTL and testbench

Parametrised, clocked successor to the benchmark's counter-based Trojan trigger. It watches a wide data bus, such as the AES ciphertext, and counts qualifying events of a selectable kind. It raises `tj_trig` when the count reaches a programmable threshold, either latched or as a repeating one-cycle pulse. The block sits beside the cipher core and drives the payload's trigger input; it is a detection-research benchmark block.

---
 rtl/trojan_trig_pkg.sv | 18 +
 rtl/tj_event_detect.sv | 56 +++++
 rtl/trojan_trigger_param.sv | 112 +++++++++++
 tb/tb_trojan_trigger_param.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trojan_trig_pkg.sv
// Shared types and constants for the parametrised counter-based trigger.
package trojan_trig_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  localparam int MODE_CHANGE = 0;
  localparam int MODE_MATCH  = 1;
  localparam int MODE_CONSEC = 2;

  function automatic logic mode_legal(input int mode);
    return (mode == MODE_CHANGE) || (mode == MODE_MATCH) || (mode == MODE_CONSEC);
  endfunction

endpackage

// File: rtl/tj_event_detect.sv
// Qualifies beats of the watched bus into one-bit event / mismatch strobes.
module tj_event_detect
  import trojan_trig_pkg::*;
#(
  parameter int                DATA_W  = 128,
  parameter int                MODE    = 0,
  parameter logic [DATA_W-1:0] PATTERN = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              event_o,
  output logic              mismatch_o
);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_ok_q, prev_ok_d;
  logic              match;
  logic              changed;

  always_comb begin
    match   = (data_i == PATTERN);
    changed = prev_ok_q && (data_i != prev_q);
    if (MODE == MODE_CHANGE) begin
      event_o = sample_i && changed;
    end else begin
      event_o = sample_i && match;
    end
    mismatch_o = sample_i && !match && (MODE == MODE_CONSEC);
  end

  // clear wins over a same-cycle beat so leaving ARMED never leaves a stale reference
  always_comb begin
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    if (clear_i) begin
      prev_ok_d = 1'b0;
    end else if (sample_i) begin
      prev_d    = data_i;
      prev_ok_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
    end
  end

endmodule

// File: rtl/trojan_trigger_param.sv
// Counts qualifying bus events and fires tj_trig when the count reaches THRESH.
module trojan_trigger_param
  import trojan_trig_pkg::*;
#(
  parameter int                DATA_W  = 128,
  parameter int                CNT_W   = 32,
  parameter logic [CNT_W-1:0]  THRESH  = '1,
  parameter int                MODE    = 0,
  parameter logic [DATA_W-1:0] PATTERN = '0,
  parameter int                STICKY  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              tj_trig,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [1:0]        state_o
);

  if (THRESH == '0) begin : g_thresh_chk
    $error("trojan_trigger_param: THRESH must be at least 1");
  end
  if (!mode_legal(MODE)) begin : g_mode_chk
    $error("trojan_trigger_param: MODE must be 0, 1 or 2");
  end
  if ((STICKY != 0) && (STICKY != 1)) begin : g_sticky_chk
    $error("trojan_trigger_param: STICKY must be 0 or 1");
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             trig_q;

  logic sample;
  logic clear;
  logic evt;
  logic mismatch;
  logic at_last;

  // Beats only qualify in ARMED with arm still high; a falling arm takes priority.
  assign sample  = (state_q == ARMED) && arm && data_valid;
  assign clear   = (state_q == IDLE) || ((state_q == ARMED) && !arm);
  assign at_last = (cnt_q == (THRESH - CNT_W'(1)));

  tj_event_detect #(
    .DATA_W  (DATA_W),
    .MODE    (MODE),
    .PATTERN (PATTERN)
  ) u_detect (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_i   (sample),
    .clear_i    (clear),
    .data_i     (data_in),
    .event_o    (evt),
    .mismatch_o (mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          trig_q <= 1'b0;
          if (arm) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (!arm) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (evt) begin
            if (at_last) begin
              state_q <= FIRED;
              cnt_q   <= THRESH;
              trig_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (mismatch) begin
            cnt_q <= '0;
          end
        end
        FIRED: begin
          // Non-sticky builds hold FIRED for one cycle only and then re-arm.
          if (STICKY == 0) begin
            trig_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= arm ? ARMED : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          trig_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tj_trig = trig_q;
  assign cnt_o   = cnt_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_trojan_trigger_param.sv
// Bench for trojan_trigger_param: four configurations share one stimulus bus.
module tb_trojan_trigger_param;

  localparam logic [7:0] PAT = 8'h5A;
  localparam logic [7:0] A_V = 8'h11;
  localparam logic [7:0] B_V = 8'h22;
  localparam logic [7:0] X_V = 8'h33;

  // 0: change/4/sticky, 1: change/3/pulse, 2: match/2/pulse, 3: consec/3/sticky
  localparam int CFG_MODE[4]   = '{0, 0, 1, 2};
  localparam int CFG_THR[4]    = '{4, 3, 2, 3};
  localparam int CFG_STICKY[4] = '{1, 0, 0, 1};

  logic       clk;
  logic       rst_n;
  logic       arm;
  logic       data_valid;
  logic [7:0] data_in;

  logic        tj[4];
  logic [31:0] cnt[4];
  logic [1:0]  st[4];

  int n_checks;
  int n_fail;

  // reference model: plain per-configuration bookkeeping
  int         m_phase[4];
  int         m_cnt[4];
  bit         m_trig[4];
  bit         m_have[4];
  logic [7:0] m_last[4];

  trojan_trigger_param #(.DATA_W(8), .CNT_W(32), .THRESH(32'd4), .MODE(0), .PATTERN(PAT), .STICKY(1))
  u_chg (.clk(clk), .rst_n(rst_n), .arm(arm), .data_valid(data_valid), .data_in(data_in),
         .tj_trig(tj[0]), .cnt_o(cnt[0]), .state_o(st[0]));

  trojan_trigger_param #(.DATA_W(8), .CNT_W(32), .THRESH(32'd3), .MODE(0), .PATTERN(PAT), .STICKY(0))
  u_chg_p (.clk(clk), .rst_n(rst_n), .arm(arm), .data_valid(data_valid), .data_in(data_in),
           .tj_trig(tj[1]), .cnt_o(cnt[1]), .state_o(st[1]));

  trojan_trigger_param #(.DATA_W(8), .CNT_W(32), .THRESH(32'd2), .MODE(1), .PATTERN(PAT), .STICKY(0))
  u_match (.clk(clk), .rst_n(rst_n), .arm(arm), .data_valid(data_valid), .data_in(data_in),
           .tj_trig(tj[2]), .cnt_o(cnt[2]), .state_o(st[2]));

  trojan_trigger_param #(.DATA_W(8), .CNT_W(32), .THRESH(32'd3), .MODE(2), .PATTERN(PAT), .STICKY(1))
  u_consec (.clk(clk), .rst_n(rst_n), .arm(arm), .data_valid(data_valid), .data_in(data_in),
            .tj_trig(tj[3]), .cnt_o(cnt[3]), .state_o(st[3]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_phase[i] = 0;
      m_cnt[i]   = 0;
      m_trig[i]  = 1'b0;
      m_have[i]  = 1'b0;
      m_last[i]  = '0;
    end
  endfunction

  function automatic void model_step(input int i, input bit a, input bit v, input logic [7:0] d);
    bit ev;
    ev = 1'b0;
    if (m_phase[i] == 2) begin
      if (CFG_STICKY[i] == 0) begin
        m_trig[i]  = 1'b0;
        m_cnt[i]   = 0;
        m_phase[i] = a ? 1 : 0;
      end
    end else if (m_phase[i] == 1) begin
      if (!a) begin
        m_phase[i] = 0;
        m_cnt[i]   = 0;
        m_have[i]  = 1'b0;
      end else if (v) begin
        if (CFG_MODE[i] == 0) begin
          ev        = m_have[i] && (d != m_last[i]);
          m_last[i] = d;
          m_have[i] = 1'b1;
        end else begin
          ev = (d == PAT);
        end
        if (ev) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == CFG_THR[i]) begin
            m_phase[i] = 2;
            m_trig[i]  = 1'b1;
          end
        end else if (CFG_MODE[i] == 2) begin
          m_cnt[i] = 0;
        end
      end
    end else begin
      m_have[i] = 1'b0;
      if (a) m_phase[i] = 1;
    end
  endfunction

  // driver tasks
  task automatic step(input bit a, input bit v, input logic [7:0] d);
    arm        = a;
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i, a, v, d);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    arm        = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    arm        = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    #3;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tj[i] !== 1'b0 || cnt[i] !== 32'd0 || st[i] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset inst%0d: trig=%b cnt=%0d state=%0d, required 0/0/0", i, tj[i], cnt[i], st[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_change_fire();
    logic [7:0] beats[5];
    beats = '{A_V, B_V, A_V, B_V, A_V};
    do_reset();
    step(1, 0, '0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, beats[k]);
      n_checks++;
      if (cnt[0] !== 32'(k) || tj[0] !== (k == 4)) begin
        n_fail++;
        $display("FAIL change_fire beat%0d: cnt=%0d trig=%b, required cnt=%0d trig=%b",
                 k, cnt[0], tj[0], k, (k == 4));
      end
    end
    for (int k = 0; k < 20; k++) begin
      step(k[0], k[1], 8'(k));
      n_checks++;
      if (tj[0] !== 1'b1 || cnt[0] !== 32'd4 || st[0] !== 2'd2) begin
        n_fail++;
        $display("FAIL sticky_hold cyc%0d: trig=%b cnt=%0d state=%0d, required 1/4/2", k, tj[0], cnt[0], st[0]);
      end
    end
  endtask

  task automatic test_no_change();
    do_reset();
    step(1, 0, '0);
    for (int k = 0; k < 5; k++) step(1, 1, A_V);
    n_checks++;
    if (cnt[0] !== 32'd0 || tj[0] !== 1'b0 || st[0] !== 2'd1) begin
      n_fail++;
      $display("FAIL no_change: cnt=%0d trig=%b state=%0d, required 0/0/1", cnt[0], tj[0], st[0]);
    end
  endtask

  task automatic test_consec();
    logic [7:0]  beats[6];
    logic [31:0] exp_c[6];
    beats = '{PAT, PAT, X_V, PAT, PAT, PAT};
    exp_c = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd3};
    do_reset();
    step(1, 0, '0);
    for (int k = 0; k < 6; k++) begin
      step(1, 1, beats[k]);
      n_checks++;
      if (cnt[3] !== exp_c[k] || tj[3] !== (k == 5)) begin
        n_fail++;
        $display("FAIL consec beat%0d: cnt=%0d trig=%b, required cnt=%0d trig=%b",
                 k, cnt[3], tj[3], exp_c[k], (k == 5));
      end
    end
  endtask

  task automatic test_pulse();
    logic [31:0] exp_c[4];
    logic        exp_t[4];
    logic [1:0]  exp_s[4];
    exp_c = '{32'd1, 32'd2, 32'd0, 32'd1};
    exp_t = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_s = '{2'd1, 2'd2, 2'd1, 2'd1};
    do_reset();
    step(1, 0, '0);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, PAT);
      n_checks++;
      if (cnt[2] !== exp_c[k] || tj[2] !== exp_t[k] || st[2] !== exp_s[k]) begin
        n_fail++;
        $display("FAIL pulse beat%0d: cnt=%0d trig=%b state=%0d, required %0d/%b/%0d",
                 k, cnt[2], tj[2], st[2], exp_c[k], exp_t[k], exp_s[k]);
      end
    end
  endtask

  task automatic test_arm_drop();
    do_reset();
    step(1, 0, '0);
    step(1, 1, A_V);
    step(1, 1, B_V);
    step(1, 1, A_V);
    step(1, 1, B_V);
    n_checks++;
    if (cnt[0] !== 32'd3) begin
      n_fail++;
      $display("FAIL arm_drop_pre: cnt=%0d, required 3", cnt[0]);
    end
    // falling arm coincides with what would be the firing change event
    step(0, 1, A_V);
    n_checks++;
    if (cnt[0] !== 32'd0 || st[0] !== 2'd0 || tj[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_drop: cnt=%0d state=%0d trig=%b, required 0/0/0", cnt[0], st[0], tj[0]);
    end
    step(1, 0, '0);
    step(1, 1, B_V);
    n_checks++;
    if (cnt[0] !== 32'd0 || st[0] !== 2'd1) begin
      n_fail++;
      $display("FAIL rearm_first_beat: cnt=%0d state=%0d, required 0/1", cnt[0], st[0]);
    end
    step(1, 1, A_V);
    n_checks++;
    if (cnt[0] !== 32'd1 || tj[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_event: cnt=%0d trig=%b, required 1/0", cnt[0], tj[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, '0);
    step(1, 1, A_V);
    step(1, 1, B_V);
    step(1, 1, A_V);
    step(1, 1, B_V);
    step(1, 1, A_V);
    n_checks++;
    if (st[0] !== 2'd2 || tj[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: state=%0d trig=%b, required 2/1", st[0], tj[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tj[0] !== 1'b0 || cnt[0] !== 32'd0 || st[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL async_low: trig=%b cnt=%0d state=%0d, required 0/0/0", tj[0], cnt[0], st[0]);
    end
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (tj[0] !== 1'b0 || cnt[0] !== 32'd0 || st[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL async_after: trig=%b cnt=%0d state=%0d, required 0/0/0", tj[0], cnt[0], st[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] pick[4];
    logic [7:0] d;
    bit         a;
    bit         v;
    pick = '{PAT, A_V, B_V, PAT};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 80 == 79) do_reset();
      a = ($urandom_range(0, 19) != 0);
      v = ($urandom_range(0, 3) != 0);
      d = pick[$urandom_range(0, 3)];
      step(a, v, d);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (tj[i] !== m_trig[i] || cnt[i] !== 32'(m_cnt[i]) || st[i] !== 2'(m_phase[i])) begin
          n_fail++;
          $display("FAIL random c%0d inst%0d: trig=%b cnt=%0d state=%0d, required %b/%0d/%0d",
                   c, i, tj[i], cnt[i], st[i], m_trig[i], m_cnt[i], m_phase[i]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    test_reset();
    test_change_fire();
    test_no_change();
    test_consec();
    test_pulse();
    test_arm_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
